// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronised line sampling, 11-bit frame decode, FWFT scancode FIFO.
// A byte appears one cycle after its stop bit is sampled; a push into a full FIFO is dropped and flags overflow.
module ps2_kb_rx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       PS2_KBCLK,
  input  logic       PS2_KBDAT,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] scancode,
  output logic       valid,
  output logic [4:0] count,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1_q, clk_s_q, clk_d_q, dat_s1_q, dat_s_q;
  logic fall;

  state_t          state_q, state_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      sr_q, sr_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            valid_q, valid_d;
  logic [7:0]      scancode_q, scancode_d;
  logic            perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  logic push_req, perr_ev, ferr_ev, ovf_ev, push_ok, pop, full;

  assign fall = clk_d_q & ~clk_s_q;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    par_d     = par_q;
    tmo_d     = '0;
    push_req  = 1'b0;
    perr_ev   = 1'b0;
    ferr_ev   = 1'b0;
    case (state_q)
      IDLE: if (fall && !dat_s_q) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
      end
      DATA: if (fall) begin
        sr_d      = {dat_s_q, sr_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = dat_s_q;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (!dat_s_q)           ferr_ev  = 1'b1;
        else if (^{sr_q, par_q}) push_req = 1'b1;
        else                    perr_ev  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Stalled mid-frame: abandon it once the line has been quiet too long.
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        ferr_ev = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_comb begin
    pop     = rd_en & valid_q;
    full    = (count_q == 5'(FIFO_DEPTH));
    push_ok = push_req & (~full | pop);
    ovf_ev  = push_req & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = sr_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    valid_d    = (count_d != 5'd0);
    scancode_d = mem_d[rd_ptr_d];

    perr_d = (perr_q & ~err_clr) | perr_ev;
    ferr_d = (ferr_q & ~err_clr) | ferr_ev;
    ovf_d  = (ovf_q  & ~err_clr) | ovf_ev;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clk_s1_q   <= 1'b1;
      clk_s_q    <= 1'b1;
      clk_d_q    <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s_q    <= 1'b1;
      state_q    <= IDLE;
      bit_idx_q  <= 3'd0;
      sr_q       <= 8'h00;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      valid_q    <= 1'b0;
      scancode_q <= 8'h00;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_s1_q   <= PS2_KBCLK;
      clk_s_q    <= clk_s1_q;
      clk_d_q    <= clk_s_q;
      dat_s1_q   <= PS2_KBDAT;
      dat_s_q    <= dat_s1_q;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      sr_q       <= sr_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      scancode_q <= scancode_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign scancode   = scancode_q;
  assign valid      = valid_q;
  assign count      = count_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_kb_rx.sv
// Bench for ps2_kb_rx: directed PS/2 frames against a queue-based reference model.
module tb_ps2_kb_rx;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst, kbclk, kbdat, rd_en, err_clr;
  logic [7:0] scancode;
  logic       valid;
  logic [4:0] count;
  logic       parity_err, frame_err, overflow;

  ps2_kb_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(10000)) dut (
    .CLOCK_50(clk), .RESET(rst), .PS2_KBCLK(kbclk), .PS2_KBDAT(kbdat),
    .rd_en(rd_en), .err_clr(err_clr), .scancode(scancode), .valid(valid),
    .count(count), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  byte unsigned mq[$];
  bit m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
  logic [7:0] exp_seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] fill    [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] refill  [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is judged as a whole by its stop bit, odd parity and FIFO room.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    if (!s)                                m_ferr = 1'b1;
    else if ($countones({d, p}) % 2 != 1)  m_perr = 1'b1;
    else if (mq.size() < DEPTH)            mq.push_back(d);
    else                                   m_ovf = 1'b1;
  endtask

  task automatic model_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid", {31'd0, valid}, {31'd0, mq.size() != 0});
      chk("count", {27'd0, count}, mq.size());
      if (mq.size() != 0) chk("scancode", {24'd0, scancode}, {24'd0, mq[0]});
      chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk); kbdat = b;
    repeat (HALF) @(negedge clk);
    kbclk = 1'b0;
    repeat (HALF) @(negedge clk);
    kbclk = 1'b1;
  endtask

  // The stop-bit fall lands in the DUT a few cycles later; the per-cycle compare
  // pauses across that window and resumes once the model has absorbed the frame.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit pop_at_push);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    @(negedge clk); kbdat = s;
    repeat (HALF) @(negedge clk);
    chk_en = 1'b0;
    kbclk  = 1'b0;
    if (pop_at_push) begin
      repeat (2) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
      model_pop();
    end else begin
      repeat (5) @(negedge clk);
    end
    model_frame(d, p, s);
    chk_en = 1'b1;
    repeat (HALF - 5) @(negedge clk);
    kbclk = 1'b1;
    kbdat = 1'b1;
  endtask

  task automatic do_pop();
    @(negedge clk); rd_en = 1'b1; model_pop();
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk); err_clr = 1'b1; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; kbclk = 1'b1; kbdat = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_scancode", {24'd0, scancode}, 0);
    chk("rst_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single good frame, then a pop, then a pop on an empty FIFO.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", {31'd0, valid}, 1);
    chk("t1_code", {24'd0, scancode}, 8'h1C);
    chk("t1_count", {27'd0, count}, 1);
    chk("t1_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    do_pop();
    chk("t1_pop_valid", {31'd0, valid}, 0);
    chk("t1_pop_count", {27'd0, count}, 0);
    do_pop();

    // Parity error, then clear.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    chk("t2_perr", {31'd0, parity_err}, 1);
    chk("t2_count", {27'd0, count}, 0);
    do_clr();
    chk("t2_perr_clr", {31'd0, parity_err}, 0);

    // Stop bit low with bad parity too: frame error wins.
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    chk("t2b_ferr", {31'd0, frame_err}, 1);
    chk("t2b_perr", {31'd0, parity_err}, 0);
    do_clr();

    // Overflow and in-order drain.
    for (int i = 0; i < 5; i++) send_frame(fill[i], ~^fill[i], 1'b1, 1'b0);
    chk("t3_count", {27'd0, count}, 4);
    chk("t3_ovf", {31'd0, overflow}, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", {24'd0, scancode}, {24'd0, exp_seq[i]});
      do_pop();
    end
    chk("t3_empty", {27'd0, count}, 0);
    do_clr();

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 4; i++) send_frame(refill[i], ~^refill[i], 1'b1, 1'b0);
    send_frame(8'hE5, ~^8'hE5, 1'b1, 1'b1);
    chk("t3b_count", {27'd0, count}, 4);
    chk("t3b_ovf", {31'd0, overflow}, 0);
    chk("t3b_head", {24'd0, scancode}, 8'hB2);
    for (int i = 0; i < 4; i++) do_pop();

    // Lone fall with data high while idle is ignored.
    send_bit(1'b1);
    chk("t6_count", {27'd0, count}, 0);
    chk("t6_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    send_frame(8'h5A, ~^8'h5A, 1'b1, 1'b0);
    chk("t6_code", {24'd0, scancode}, 8'h5A);
    do_pop();

    // Timeout after start plus four data bits.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h1C >> i));
    repeat (9900) @(negedge clk);
    chk("t4_no_early_ferr", {31'd0, frame_err}, 0);
    chk_en = 1'b0;
    repeat (200) @(negedge clk);
    m_ferr = 1'b1;
    chk_en = 1'b1;
    chk("t4_ferr", {31'd0, frame_err}, 1);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t4_code", {24'd0, scancode}, 8'h1C);
    chk("t4_count", {27'd0, count}, 1);

    // Asynchronous reset mid-frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h76 >> i));
    chk_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", {31'd0, valid}, 0);
    chk("t5_count", {27'd0, count}, 0);
    chk("t5_scancode", {24'd0, scancode}, 0);
    chk("t5_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    mq.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    send_frame(8'h76, 1'b0, 1'b1, 1'b0);
    chk("t5_code", {24'd0, scancode}, 8'h76);
    chk("t5_after_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    do_pop();
    repeat (5) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning scancode FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000, meaning CLOCK_50 cycles without a PS/2 clock fall before an open frame is abandoned.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports PS2_KBCLK and PS2_KBDAT  input  1 each  raw keyboard clock and data lines, asynchronous.
REQ-006 SHALL have port rd_en  input  1  core pop request for the FIFO head.
REQ-007 SHALL have port err_clr  input  1  clears the sticky error flags.
REQ-008 SHALL have port scancode  output  8  FIFO head byte; valid only while valid=1.
REQ-009 SHALL have port valid  output  1  FIFO non-empty.
REQ-010 SHALL have port count  output  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 SHALL have ports parity_err, frame_err and overflow  output  1 each  sticky error flags.

Function
REQ-012 SHALL pass PS2_KBCLK and PS2_KBDAT each through a 2-flop synchronizer (clk_s, dat_s), register clk_s into clk_d, and define fall = clk_d & ~clk_s.
REQ-013 SHALL use states IDLE, DATA, PARITY and STOP, and SHALL act only in cycles where fall=1, except for the timeout and reset.
REQ-014 SHALL, in IDLE on fall: dat_s=0 -> DATA with bit index 0; dat_s=1 -> stay in IDLE with no flag change (glitch).
REQ-015 SHALL, in DATA on fall, shift dat_s in LSB first; after the 8th bit go to PARITY.
REQ-016 SHALL, in PARITY on fall, capture the parity bit and go to STOP.
REQ-017 SHALL check odd parity: XOR of the 8 data bits and the parity bit equals 1.
REQ-018 SHALL, in STOP on fall, return to IDLE and: dat_s=1 with good parity -> push byte; bad parity -> set parity_err with no push; dat_s=0 -> set frame_err with no push (frame_err takes precedence over parity_err).
REQ-019 SHALL, when a push is accepted in cycle N, show the byte on scancode (if the FIFO was empty) and update valid and count from cycle N+1.
REQ-020 SHALL implement a first-word-fall-through FIFO: rd_en=1 with valid=1 pops the head in that cycle; rd_en with valid=0 is ignored.
REQ-021 SHALL resolve simultaneous push and pop as follows: both happen and count is unchanged; this applies when the FIFO is full.
REQ-022 SHALL, on a push to a full FIFO without a pop in the same cycle, drop the byte, set overflow, and leave the FIFO contents unchanged.
REQ-023 SHALL use a bit-timeout counter outside IDLE that clears on each fall; on reaching TIMEOUT_CYCLES the block goes to IDLE, sets frame_err and discards the partial byte.
REQ-024 SHALL clear all sticky flags on err_clr=1; an error event in the same cycle as err_clr takes precedence and the flag stays set.
REQ-025 SHALL wrap the read and write pointers modulo FIFO_DEPTH.

Reset
REQ-026 SHALL, while RESET=1 (immediately, without waiting for a clock edge), force state=IDLE, the synchronizers and clk_d to 1, FIFO pointers and count to 0, valid=0, scancode=0x00, all flags 0, and the timeout counter to 0.
REQ-027 SHALL, when RESET is asserted mid-frame, discard the partial frame, and SHALL resume reception after release only at the next start bit.

Verification
REQ-028 Bench SHALL cover: frame 0x1C with parity 0 and stop 1, then no rd_en -> valid=1, scancode=0x1C, count=1, no flags; then one rd_en -> valid=0, count=0.
REQ-029 Bench SHALL cover: frame 0xF0 with parity bit 0 (wrong) -> parity_err=1, count=0; then err_clr pulse -> parity_err=0.
REQ-030 Bench SHALL cover: frames 0x11, 0x22, 0x33, 0x44, 0x55 with no reads -> count=4, overflow=1, and pops return 0x11, 0x22, 0x33, 0x44 in order; then a push and pop in the same cycle at full -> count stays 4.
REQ-031 Bench SHALL cover: start bit plus 4 data bits, then idle for more than 10000 cycles -> frame_err=1, state IDLE; then full frame 0x1C -> received correctly.
REQ-032 Bench SHALL cover: RESET pulse after 5 bits of a frame -> all outputs 0 at once; then full frame 0x76 (parity 0) -> scancode=0x76, no flags.
REQ-033 Bench SHALL cover: a single fall with PS2_KBDAT=1 while in IDLE -> no state change and no flags; the next valid frame is received.
